// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multdiv unit: latches an issue, pulses start, stalls until the result retires.
// Optional watchdog enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_ctrl #(
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_op,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic        flush,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mult_q, mult_d;
    logic              div_q, div_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              timeout_err_q, timeout_err_d;
    logic              accept;
    logic              timeout_hit;

    assign accept = issue_valid & ~flush;

`ifdef MULTDIV_TIMEOUT_EN
    assign timeout_hit = (cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        mult_d        = 1'b0;
        div_d         = 1'b0;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = issue_op;
                    rd_d    = issue_rd;
                    a_d     = issue_a;
                    b_d     = issue_b;
                    mult_d  = ~issue_op;
                    div_d   = issue_op;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = flush ? IDLE : WAIT;
            end
            WAIT: begin
                // Saturate at the watchdog threshold so the counter never wraps.
                cnt_d = (cnt_q == TO_LAST) ? cnt_q : cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = IDLE;
                end else if (md_resultRDY) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = md_exception ? 5'd30 : rd_q;
                    wb_data_d  = md_exception ? (op_q ? 32'd5 : 32'd4) : md_result;
                end else if (timeout_hit) begin
                    state_d       = DONE;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = 5'd30;
                    wb_data_d     = op_q ? 32'd5 : 32'd4;
                    timeout_err_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            op_q          <= 1'b0;
            rd_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            mult_q        <= 1'b0;
            div_q         <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            mult_q        <= mult_d;
            div_q         <= div_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // IDLE stall is combinational so the issuing instruction freezes in its own cycle; gated by reset.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:        stall = accept & reset;
            START, WAIT: stall = ~flush;
            default:     stall = 1'b0;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign md_ctrl_mult = mult_q;
    assign md_ctrl_div  = div_q;
    assign md_operandA  = a_q;
    assign md_operandB  = b_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard testbench for multdiv_ctrl; expected writebacks are queued at issue and checked when wb_valid fires.
module tb_multdiv_ctrl;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        issue_op;
    logic [4:0]  issue_rd;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        flush;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    logic [4:0]  exp_rd[$];
    logic [31:0] exp_data[$];

    int n_mult, n_div, first_mult, first_div, n_wb, wb_cyc, stall_errs, oper_errs;
    logic busy_probe;

    multdiv_ctrl #(.CNT_W(6), .TIMEOUT(40)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b), .flush(flush),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .timeout_err(timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] hang");
    end

    // Scoreboard: every writeback beat must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset && wb_valid) begin
            checks++;
            if (exp_rd.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected got rd=%0d data=%0d, none expected", wb_rd, wb_data);
            end else begin
                logic [4:0]  er;
                logic [31:0] ed;
                er = exp_rd.pop_front();
                ed = exp_data.pop_front();
                if (wb_rd !== er || wb_data !== ed) begin
                    failures++;
                    $display("FAIL wb_beat got rd=%0d data=%0d, want rd=%0d data=%0d", wb_rd, wb_data, er, ed);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_op = 0; issue_rd = 0; issue_a = 0; issue_b = 0;
        flush = 0; md_result = 0; md_exception = 0; md_resultRDY = 0;
    endtask

    // Drives one op with cycle 0 = issue cycle; records observations for the calling test to judge.
    task automatic run_op(input logic op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input int rdy_cyc, input logic exc, input int flush_cyc, input int done_cyc,
                          input int ncyc);
        int stall_end, hold_end;
        logic [31:0] res;
        res = op ? ((b == 0) ? 32'd0 : a / b) : a * b;
        stall_end = (done_cyc >= 0) ? done_cyc - 1 : flush_cyc - 1;
        hold_end  = (done_cyc >= 0) ? done_cyc : flush_cyc - 1;
        n_mult = 0; n_div = 0; first_mult = -1; first_div = -1;
        n_wb = 0; wb_cyc = -1; stall_errs = 0; oper_errs = 0; busy_probe = 1'bx;
        if (done_cyc >= 0) begin
            exp_rd.push_back(exc ? 5'd30 : rd);
            exp_data.push_back(exc ? (op ? 32'd5 : 32'd4) : res);
        end
        for (int cyc = 0; cyc <= ncyc; cyc++) begin
            if (cyc > 0) tick();
            issue_valid  = (cyc <= hold_end);
            issue_op     = op;
            issue_rd     = rd;
            issue_a      = (cyc <= 1) ? a : ~a;
            issue_b      = (cyc <= 1) ? b : ~b;
            flush        = (cyc == flush_cyc);
            md_resultRDY = (cyc == rdy_cyc);
            md_exception = exc && (cyc == rdy_cyc);
            md_result    = (cyc == rdy_cyc) ? res : 32'hDEAD_BEEF;
            #1;
            if (md_ctrl_mult) begin n_mult++; if (first_mult < 0) first_mult = cyc; end
            if (md_ctrl_div)  begin n_div++;  if (first_div < 0)  first_div = cyc;  end
            if (stall !== (cyc <= stall_end)) stall_errs++;
            if (wb_valid) begin n_wb++; wb_cyc = cyc; end
            if (cyc == 3 && (md_operandA !== a || md_operandB !== b)) oper_errs++;
            if (cyc == flush_cyc + 1) busy_probe = busy;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({stall, busy, wb_valid, md_ctrl_mult, md_ctrl_div, timeout_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b want 000000", {stall, busy, wb_valid, md_ctrl_mult, md_ctrl_div, timeout_err});
        end
        checks++;
        if (md_operandA !== 0 || md_operandB !== 0 || wb_rd !== 0 || wb_data !== 0) begin
            failures++;
            $display("FAIL reset_data got A=%0h B=%0h rd=%0d data=%0h want all 0", md_operandA, md_operandB, wb_rd, wb_data);
        end
        #9 reset = 1'b1;
    endtask

    task automatic test_mult();
        tick();
        run_op(1'b0, 5'd5, 32'd6, 32'd7, 33, 1'b0, -1, 34, 38);
        checks++;
        if (n_mult !== 1 || first_mult !== 1 || n_div !== 0) begin
            failures++;
            $display("FAIL mult_pulse got n_mult=%0d at %0d n_div=%0d, want 1 at 1 and 0", n_mult, first_mult, n_div);
        end
        checks++;
        if (stall_errs !== 0) begin
            failures++;
            $display("FAIL mult_stall got %0d bad cycles, want 0", stall_errs);
        end
        checks++;
        if (n_wb !== 1 || wb_cyc !== 34) begin
            failures++;
            $display("FAIL mult_wb_timing got %0d beats at %0d, want 1 at 34", n_wb, wb_cyc);
        end
        checks++;
        if (oper_errs !== 0) begin
            failures++;
            $display("FAIL mult_operands got A=%0d B=%0d, want 6 7", md_operandA, md_operandB);
        end
        checks++;
        if (wb_rd !== 5'd5 || wb_data !== 32'd42) begin
            failures++;
            $display("FAIL wb_hold got rd=%0d data=%0d, want 5 42", wb_rd, wb_data);
        end
    endtask

    task automatic test_div_exception();
        tick();
        run_op(1'b1, 5'd7, 32'd9, 32'd0, 5, 1'b1, -1, 6, 9);
        checks++;
        if (n_div !== 1 || first_div !== 1 || n_mult !== 0) begin
            failures++;
            $display("FAIL div_pulse got n_div=%0d at %0d n_mult=%0d, want 1 at 1 and 0", n_div, first_div, n_mult);
        end
        checks++;
        if (n_wb !== 1 || wb_cyc !== 6 || stall_errs !== 0) begin
            failures++;
            $display("FAIL div_timing got %0d beats at %0d stall_errs=%0d, want 1 at 6 and 0", n_wb, wb_cyc, stall_errs);
        end
    endtask

    task automatic test_flush();
        tick();
        run_op(1'b0, 5'd12, 32'd3, 32'd3, 33, 1'b0, 10, -1, 40);
        checks++;
        if (n_wb !== 0) begin
            failures++;
            $display("FAIL flush_no_wb got %0d beats, want 0", n_wb);
        end
        checks++;
        if (busy_probe !== 1'b0 || stall_errs !== 0) begin
            failures++;
            $display("FAIL flush_idle got busy=%b stall_errs=%0d, want 0 and 0", busy_probe, stall_errs);
        end
    endtask

    task automatic test_back_to_back();
        int mult_cyc[$];
        int div_cyc[$];
        int wbs[$];
        int serr;
        serr = 0;
        tick();
        exp_rd.push_back(5'd3);  exp_data.push_back(32'd12);
        exp_rd.push_back(5'd4);  exp_data.push_back(32'd14);
        for (int cyc = 0; cyc <= 18; cyc++) begin
            if (cyc > 0) tick();
            issue_valid  = (cyc <= 15);
            issue_op     = (cyc >= 8);
            issue_rd     = (cyc >= 8) ? 5'd4 : 5'd3;
            issue_a      = (cyc >= 8) ? 32'd100 : 32'd3;
            issue_b      = (cyc >= 8) ? 32'd7 : 32'd4;
            md_resultRDY = (cyc == 6 || cyc == 14);
            md_result    = (cyc == 6) ? 32'd12 : ((cyc == 14) ? 32'd14 : 32'hDEAD_BEEF);
            #1;
            if (md_ctrl_mult) mult_cyc.push_back(cyc);
            if (md_ctrl_div)  div_cyc.push_back(cyc);
            if (wb_valid)     wbs.push_back(cyc);
            if (stall !== (cyc <= 6 || (cyc >= 8 && cyc <= 14))) serr++;
        end
        idle_inputs();
        checks++;
        if (wbs.size() !== 2 || wbs[0] !== 7 || wbs[1] !== 15) begin
            failures++;
            $display("FAIL b2b_wb got %0d beats (first %0d), want 2 at 7 and 15", wbs.size(), (wbs.size() > 0) ? wbs[0] : -1);
        end
        checks++;
        if (mult_cyc.size() !== 1 || div_cyc.size() !== 1 || mult_cyc[0] !== 1 || div_cyc[0] !== 9) begin
            failures++;
            $display("FAIL b2b_pulses got mult=%0d div=%0d pulses, want one each at 1 and 9", mult_cyc.size(), div_cyc.size());
        end
        checks++;
        if (serr !== 0) begin
            failures++;
            $display("FAIL b2b_stall got %0d bad cycles, want 0", serr);
        end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        issue_valid = 1; issue_op = 0; issue_rd = 5'd9; issue_a = 32'd2; issue_b = 32'd3;
        for (int cyc = 1; cyc <= 5; cyc++) tick();
        #1;
        checks++;
        if (busy !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got busy=%b stall=%b, want 1 1", busy, stall);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0 || md_operandA !== 0) begin
            failures++;
            $display("FAIL async_reset got stall=%b busy=%b wb=%b A=%0d, want 0 0 0 0", stall, busy, wb_valid, md_operandA);
        end
        #3 reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        run_op(1'b0, 5'd9, 32'd2, 32'd3, 4, 1'b0, -1, 5, 8);
        checks++;
        if (n_wb !== 1 || wb_cyc !== 5 || n_mult !== 1 || first_mult !== 1) begin
            failures++;
            $display("FAIL post_reset_op got %0d beats at %0d, mult %0d at %0d, want 1 at 5, 1 at 1", n_wb, wb_cyc, n_mult, first_mult);
        end
    endtask

`ifdef MULTDIV_TIMEOUT_EN
    task automatic test_timeout();
        tick();
        run_op(1'b0, 5'd11, 32'd5, 32'd5, -1, 1'b1, -1, 42, 45);
        checks++;
        if (n_wb !== 1 || wb_cyc !== 42 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout got %0d beats at %0d err=%b, want 1 at 42 err=1", n_wb, wb_cyc, timeout_err);
        end
        tick();
        run_op(1'b1, 5'd2, 32'd20, 32'd4, 3, 1'b0, -1, 4, 6);
        checks++;
        if (timeout_err !== 1'b1 || n_wb !== 1) begin
            failures++;
            $display("FAIL timeout_sticky got err=%b beats=%0d, want 1 1", timeout_err, n_wb);
        end
    endtask
`else
    task automatic test_timeout();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_tied got %b, want 0", timeout_err);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_mult();
        test_div_exception();
        test_flush();
        test_back_to_back();
        test_reset_mid_wait();
        test_timeout();
        tick();
        tick();
        checks++;
        if (exp_rd.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending, want 0", exp_rd.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
